boot_loader: RTL and testbench

Boot-time UART protocol engine between the byte-level UART transceiver and the CPU state controller. It executes the four boot phases the controller requests: send 0x99, receive a 4-byte program size, receive program bytes and write them as 32-bit words into instruction memory, then send 0xAA. For each phase it returns a level `*_finished` flag that lets the controller advance.

---
 rtl/boot_loader.sv | 205 ++++++++++++++++++++
 tb/tb_boot_loader.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader.sv
// Boot-time UART protocol engine: sends 0x99, receives a 4-byte size and the
// program image (packed into 32-bit instruction-memory words), then sends 0xAA.
module boot_loader #(
  parameter int INST_ADDR_WIDTH = 15
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       transmit_0x99,
  input  logic                       receive_program_data_size,
  input  logic                       receive_program_data,
  input  logic                       transmit_0xAA,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  input  logic                       tx_ready,
  output logic                       tx_start,
  output logic [7:0]                 tx_data,
  output logic                       transmit_0x99_finished,
  output logic                       receive_program_data_size_finished,
  output logic                       receive_program_data_finished,
  output logic                       transmit_0xAA_finished,
  output logic                       imem_write_enable,
  output logic [INST_ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]                imem_write_data,
  output logic [31:0]                program_size
);

  typedef enum logic [3:0] {
    IDLE,
    TX_START,
    TX_WAIT_BUSY,
    TX_WAIT_IDLE,
    TX_DONE,
    RX_SIZE,
    SIZE_DONE,
    RX_DATA,
    DATA_DONE
  } state_e;

  state_e                     state_q, state_d;
  logic                       tx_start_q, tx_start_d;
  logic [7:0]                 tx_data_q, tx_data_d;
  logic                       fin_99_q, fin_99_d;
  logic                       fin_size_q, fin_size_d;
  logic                       fin_data_q, fin_data_d;
  logic                       fin_aa_q, fin_aa_d;
  logic                       we_q, we_d;
  logic [INST_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]                wdata_q, wdata_d;
  logic [31:0]                size_q, size_d;
  logic [1:0]                 byte_cnt_q, byte_cnt_d;
  logic [29:0]                word_cnt_q, word_cnt_d;
  logic [31:0]                word_q, word_d;

  logic [29:0]                words_total;
  logic                       tx_req_held;

  // Little-endian byte assembly: the first byte received ends up in bits 7:0.
  function automatic logic [31:0] shift_in_le(input logic [31:0] acc, input logic [7:0] b);
    return {b, acc[31:8]};
  endfunction

  assign words_total = size_q[31:2];
  assign tx_req_held = (tx_data_q == 8'h99) ? transmit_0x99 : transmit_0xAA;

  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    fin_99_d   = fin_99_q;
    fin_size_d = fin_size_q;
    fin_data_d = fin_data_q;
    fin_aa_d   = fin_aa_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    size_d     = size_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    word_d     = word_q;

    case (state_q)
      IDLE: begin
        if ((transmit_0x99 || transmit_0xAA) && tx_ready) begin
          state_d    = TX_START;
          tx_start_d = 1'b1;
          tx_data_d  = transmit_0x99 ? 8'h99 : 8'hAA;
        end else if (receive_program_data_size) begin
          state_d    = RX_SIZE;
          byte_cnt_d = 2'd0;
        end else if (receive_program_data) begin
          byte_cnt_d = 2'd0;
          word_cnt_d = 30'd0;
          state_d    = (words_total == 30'd0) ? DATA_DONE : RX_DATA;
        end
      end

      TX_START: state_d = TX_WAIT_BUSY;

      TX_WAIT_BUSY: begin
        if (!tx_ready) state_d = TX_WAIT_IDLE;
      end

      TX_WAIT_IDLE: begin
        if (tx_ready) begin
          state_d  = TX_DONE;
          fin_99_d = (tx_data_q == 8'h99);
          fin_aa_d = (tx_data_q == 8'hAA);
        end
      end

      TX_DONE: begin
        fin_99_d = (tx_data_q == 8'h99) && tx_req_held;
        fin_aa_d = (tx_data_q == 8'hAA) && tx_req_held;
        if (!tx_req_held) state_d = IDLE;
      end

      RX_SIZE: begin
        if (rx_valid) begin
          size_d     = shift_in_le(size_q, rx_data);
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d    = SIZE_DONE;
            fin_size_d = 1'b1;
          end
        end
      end

      SIZE_DONE: begin
        fin_size_d = receive_program_data_size;
        if (!receive_program_data_size) state_d = IDLE;
      end

      RX_DATA: begin
        if (rx_valid) begin
          word_d     = shift_in_le(word_q, rx_data);
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            we_d       = 1'b1;
            wdata_d    = shift_in_le(word_q, rx_data);
            addr_d     = word_cnt_q[INST_ADDR_WIDTH-1:0];
            word_cnt_d = word_cnt_q + 30'd1;
            // The finished flag follows one cycle after the final strobe.
            if (word_cnt_q + 30'd1 == words_total) state_d = DATA_DONE;
          end
        end
      end

      DATA_DONE: begin
        fin_data_d = receive_program_data;
        if (!receive_program_data) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      fin_99_q   <= 1'b0;
      fin_size_q <= 1'b0;
      fin_data_q <= 1'b0;
      fin_aa_q   <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      size_q     <= 32'h0;
      byte_cnt_q <= 2'd0;
      word_cnt_q <= 30'd0;
    end else begin
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      fin_99_q   <= fin_99_d;
      fin_size_q <= fin_size_d;
      fin_data_q <= fin_data_d;
      fin_aa_q   <= fin_aa_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      size_q     <= size_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  // Partial-word accumulator; stale bytes are shifted out once the byte counter restarts.
  always_ff @(posedge clk) begin
    word_q <= word_d;
  end

  assign tx_start                           = tx_start_q;
  assign tx_data                            = tx_data_q;
  assign transmit_0x99_finished             = fin_99_q;
  assign receive_program_data_size_finished = fin_size_q;
  assign receive_program_data_finished      = fin_data_q;
  assign transmit_0xAA_finished             = fin_aa_q;
  assign imem_write_enable                  = we_q;
  assign imem_addr                          = addr_q;
  assign imem_write_data                    = wdata_q;
  assign program_size                       = size_q;

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: two instances (default and 2-bit address)
// share one stimulus stream; a monitor checks every tx_start and write strobe.
module tb_boot_loader;

  logic       clk, reset_n;
  logic       t99, rsz, rdat, taa;
  logic [7:0] rx_data;
  logic       rx_valid, tx_ready;

  logic        tx_start, f99, fsz, fdat, faa, we;
  logic [7:0]  tx_data;
  logic [14:0] addr;
  logic [31:0] wdata, psize;

  logic        tx_start2, f99_2, fsz_2, fdat_2, faa_2, we2;
  logic [7:0]  tx_data2;
  logic [1:0]  addr2;
  logic [31:0] wdata2, psize2;

  boot_loader #(.INST_ADDR_WIDTH(15)) dut (
    .clk(clk), .reset_n(reset_n),
    .transmit_0x99(t99), .receive_program_data_size(rsz),
    .receive_program_data(rdat), .transmit_0xAA(taa),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_ready(tx_ready),
    .tx_start(tx_start), .tx_data(tx_data),
    .transmit_0x99_finished(f99), .receive_program_data_size_finished(fsz),
    .receive_program_data_finished(fdat), .transmit_0xAA_finished(faa),
    .imem_write_enable(we), .imem_addr(addr), .imem_write_data(wdata),
    .program_size(psize)
  );

  boot_loader #(.INST_ADDR_WIDTH(2)) dut2 (
    .clk(clk), .reset_n(reset_n),
    .transmit_0x99(t99), .receive_program_data_size(rsz),
    .receive_program_data(rdat), .transmit_0xAA(taa),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_ready(tx_ready),
    .tx_start(tx_start2), .tx_data(tx_data2),
    .transmit_0x99_finished(f99_2), .receive_program_data_size_finished(fsz_2),
    .receive_program_data_finished(fdat_2), .transmit_0xAA_finished(faa_2),
    .imem_write_enable(we2), .imem_addr(addr2), .imem_write_data(wdata2),
    .program_size(psize2)
  );

  typedef struct {
    logic [14:0] a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    logic [1:0]  a;
    logic [31:0] d;
  } wr2_t;

  logic [7:0] txq[$];
  wr_t        wq[$];
  wr2_t       wq2[$];

  int errors = 0;
  int checks = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [14:0] a, input logic [1:0] a2, input logic [31:0] d);
    wr_t  e;
    wr2_t e2;
    e.a  = a;  e.d  = d;
    e2.a = a2; e2.d = d;
    wq.push_back(e);
    wq2.push_back(e2);
  endtask

  // Monitor: every strobe the DUT presents is matched against the scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      if (tx_start) begin
        if (txq.size() == 0) chk("tx_start_unexpected", {31'b0, tx_start}, 32'd0);
        else chk("tx_data", {24'b0, tx_data}, {24'b0, txq.pop_front()});
      end
      if (we) begin
        if (wq.size() == 0) chk("write_unexpected", {31'b0, we}, 32'd0);
        else begin
          wr_t e;
          e = wq.pop_front();
          chk("imem_addr", {17'b0, addr}, {17'b0, e.a});
          chk("imem_write_data", wdata, e.d);
        end
      end
      if (we2) begin
        if (wq2.size() == 0) chk("write2_unexpected", {31'b0, we2}, 32'd0);
        else begin
          wr2_t e2;
          e2 = wq2.pop_front();
          chk("imem_addr_w2", {30'b0, addr2}, {30'b0, e2.a});
          chk("imem_write_data_w2", wdata2, e2.d);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_tx"}, {23'b0, tx_start, tx_data}, 32'd0);
    chk({tag, "_fin"}, {28'b0, f99, fsz, fdat, faa}, 32'd0);
    chk({tag, "_we_addr"}, {16'b0, we, addr}, 32'd0);
    chk({tag, "_wdata"}, wdata, 32'd0);
    chk({tag, "_size"}, psize, 32'd0);
  endtask

  task automatic size_phase(input logic [31:0] sz);
    rsz = 1'b1;
    step();
    for (int i = 0; i < 4; i++) send_byte(sz[8*i +: 8]);
    chk("program_size", psize, sz);
    chk("size_finished", {31'b0, fsz}, 32'd1);
    rsz = 1'b0;
    step();
    chk("size_finished_clear", {31'b0, fsz}, 32'd0);
  endtask

  logic [7:0] img12 [12];

  initial begin
    img12 = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00,
              8'hEF, 8'hBE, 8'hAD, 8'hDE};
    t99 = 0; rsz = 0; rdat = 0; taa = 0;
    rx_data = 8'h00; rx_valid = 0; tx_ready = 1;
    reset_n = 1'b1;
    #3 reset_n = 1'b0;
    #1 check_zero("reset");
    step(); step();
    reset_n = 1'b1;
    step();

    // Send 0x99 with a 100-cycle busy transmitter; rx noise must be ignored.
    t99 = 1'b1;
    txq.push_back(8'h99);
    step();
    chk("tx_start_latency", {31'b0, tx_start}, 32'd1);
    tx_ready = 1'b0;
    for (int i = 0; i < 100; i++) begin
      rx_valid = (i % 25 == 3);
      rx_data  = 8'hA5;
      step();
    end
    rx_valid = 1'b0;
    chk("f99_before_ready", {31'b0, f99}, 32'd0);
    chk("size_untouched_tx", psize, 32'd0);
    tx_ready = 1'b1;
    step();
    chk("f99_set", {31'b0, f99}, 32'd1);
    step(); step();
    chk("f99_held", {31'b0, f99}, 32'd1);
    t99 = 1'b0;
    step();
    chk("f99_clear", {31'b0, f99}, 32'd0);

    for (int i = 0; i < 3; i++) send_byte(8'h5A);
    chk("size_untouched_idle", psize, 32'd0);

    // 12-byte program at back-to-back byte rate.
    size_phase(32'd12);
    push_wr(15'd0, 2'd0, 32'h0000_0013);
    push_wr(15'd1, 2'd1, 32'h0010_0093);
    push_wr(15'd2, 2'd2, 32'hDEAD_BEEF);
    rdat = 1'b1;
    step();
    for (int i = 0; i < 12; i++) send_byte(img12[i]);
    chk("data_fin_early", {31'b0, fdat}, 32'd0);
    step();
    chk("data_fin_12", {31'b0, fdat}, 32'd1);
    rdat = 1'b0;
    step();
    chk("data_fin_12_clear", {31'b0, fdat}, 32'd0);

    // Zero-length program.
    size_phase(32'd0);
    rdat = 1'b1;
    step();
    chk("zero_fin_1cyc", {31'b0, fdat}, 32'd0);
    step();
    chk("zero_fin_2cyc", {31'b0, fdat}, 32'd1);
    rdat = 1'b0;
    step();

    // Size 6: one word, trailing bytes never consumed.
    size_phase(32'd6);
    push_wr(15'd0, 2'd0, 32'h4433_2211);
    rdat = 1'b1;
    step();
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    step();
    chk("size6_fin", {31'b0, fdat}, 32'd1);
    send_byte(8'h55); send_byte(8'h66);
    rdat = 1'b0;
    step();
    chk("size6_fin_clear", {31'b0, fdat}, 32'd0);

    // Reset in the middle of a word.
    size_phase(32'd8);
    rdat = 1'b1;
    step();
    send_byte(8'hAB); send_byte(8'hCD);
    reset_n = 1'b0;
    #1 check_zero("midreset");
    rdat = 1'b0;
    step(); step();
    reset_n = 1'b1;
    step();

    // 20 bytes: narrow instance wraps the fifth word to address 0.
    size_phase(32'd20);
    push_wr(15'd0, 2'd0, 32'hC0B0_A001);
    push_wr(15'd1, 2'd1, 32'hC0B0_A002);
    push_wr(15'd2, 2'd2, 32'hC0B0_A003);
    push_wr(15'd3, 2'd3, 32'hC0B0_A004);
    push_wr(15'd4, 2'd0, 32'hC0B0_A005);
    rdat = 1'b1;
    step();
    for (int k = 0; k < 5; k++) begin
      send_byte(8'(k + 1)); send_byte(8'hA0); send_byte(8'hB0); send_byte(8'hC0);
    end
    step();
    chk("data_fin_20", {31'b0, fdat}, 32'd1);
    rdat = 1'b0;
    step();

    // Final 0xAA handshake.
    taa = 1'b1;
    txq.push_back(8'hAA);
    step();
    tx_ready = 1'b0;
    step(); step(); step();
    tx_ready = 1'b1;
    step();
    chk("faa_set", {31'b0, faa}, 32'd1);
    chk("f99_quiet", {31'b0, f99}, 32'd0);
    taa = 1'b0;
    step();
    chk("faa_clear", {31'b0, faa}, 32'd0);

    step(); step();
    chk("txq_drained", txq.size(), 32'd0);
    chk("wq_drained", wq.size(), 32'd0);
    chk("wq2_drained", wq2.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule
